parity_stream_engine: RTL and testbench

Parametrised, sequential successor to the 8-bit combinational UART parity generator. It accepts a data word over a valid/ready handshake and folds the parity over DATA_WIDTH/BITS_PER_CYCLE clock cycles. It then presents the word plus its parity bit over a second valid/ready handshake. A check mode compares the computed parity against a received parity bit, raises an error flag and keeps a saturating error count. It sits between the UART Tx/Rx datapaths and the frame serialiser/deserialiser.

---
 rtl/parity_stream_engine.sv | 99 +++++++++
 tb/tb_parity_stream_engine.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/parity_stream_engine.sv
// parity_stream_engine: multi-cycle parity generator/checker with valid/ready handshakes on both sides.
module parity_stream_engine #(
    parameter int DATA_WIDTH     = 8,
    parameter int BITS_PER_CYCLE = 1,
    parameter int CNT_WIDTH      = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [1:0]            i_parity_type,
    input  logic                  i_check_mode,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [DATA_WIDTH-1:0] i_in_data,
    input  logic                  i_in_parity,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [DATA_WIDTH-1:0] o_out_data,
    output logic                  o_out_parity,
    output logic                  o_parity_error,
    output logic [CNT_WIDTH-1:0]  o_error_count,
    input  logic                  i_clear_count
);
    localparam int N  = DATA_WIDTH / BITS_PER_CYCLE;
    localparam int BW = N > 1 ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [1:0]            r_type;
    logic                  r_check;
    logic                  r_in_parity;
    logic                  r_acc;
    logic [BW-1:0]         r_beat;
    logic                  w_x;
    logic                  w_par;
    logic                  w_err;

    // w_x is the accumulator including the chunk folded on this edge
    assign w_x   = r_acc ^ (^r_shift[BITS_PER_CYCLE-1:0]);
    assign w_par = r_type == 2'b01 ? ~w_x : r_type == 2'b10 ? w_x : 1'b0;
    assign w_err = r_check & (r_type == 2'b01 || r_type == 2'b10) & (r_in_parity != w_par);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= IDLE;
            r_data         <= '0;
            r_shift        <= '0;
            r_type         <= '0;
            r_check        <= 1'b0;
            r_in_parity    <= 1'b0;
            r_acc          <= 1'b0;
            r_beat         <= '0;
            o_in_ready     <= 1'b1;
            o_out_valid    <= 1'b0;
            o_out_data     <= '0;
            o_out_parity   <= 1'b0;
            o_parity_error <= 1'b0;
            o_error_count  <= '0;
        end else begin
            if (i_clear_count)
                o_error_count <= '0;
            else if (r_state == DONE && i_out_ready && o_parity_error && o_error_count != '1)
                o_error_count <= o_error_count + 1'b1;
            case (r_state)
                IDLE: if (i_in_valid) begin
                    r_data      <= i_in_data;
                    r_shift     <= i_in_data;
                    r_type      <= i_parity_type;
                    r_check     <= i_check_mode;
                    r_in_parity <= i_in_parity;
                    r_acc       <= 1'b0;
                    r_beat      <= '0;
                    o_in_ready  <= 1'b0;
                    r_state     <= SHIFT;
                end
                SHIFT: begin
                    r_acc   <= w_x;
                    r_shift <= r_shift >> BITS_PER_CYCLE;
                    r_beat  <= r_beat + 1'b1;
                    if (r_beat == BW'(N - 1)) begin
                        o_out_data     <= r_data;
                        o_out_parity   <= w_par;
                        o_parity_error <= w_err;
                        o_out_valid    <= 1'b1;
                        r_state        <= DONE;
                    end
                end
                DONE: if (i_out_ready) begin
                    o_out_valid <= 1'b0;
                    o_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_parity_stream_engine.sv
// tb_parity_stream_engine: directed vectors against 8x1 and 8x4 configurations of the parity engine.
module tb_parity_stream_engine;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] ptype = 2'b00;
    logic       chk = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_par = 1'b0;
    logic       out_ready = 1'b0;
    logic       clr = 1'b0;
    logic       rdy8, val8, par8, err8;
    logic [7:0] data8;
    logic [3:0] cnt8;
    logic       rdy4, val4, par4, err4;
    logic [7:0] data4;
    logic [3:0] cnt4;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    parity_stream_engine #(.DATA_WIDTH(8), .BITS_PER_CYCLE(1), .CNT_WIDTH(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_parity_type(ptype), .i_check_mode(chk),
        .i_in_valid(in_valid), .o_in_ready(rdy8), .i_in_data(in_data), .i_in_parity(in_par),
        .o_out_valid(val8), .i_out_ready(out_ready), .o_out_data(data8), .o_out_parity(par8),
        .o_parity_error(err8), .o_error_count(cnt8), .i_clear_count(clr)
    );

    parity_stream_engine #(.DATA_WIDTH(8), .BITS_PER_CYCLE(4), .CNT_WIDTH(4)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_parity_type(ptype), .i_check_mode(chk),
        .i_in_valid(in_valid), .o_in_ready(rdy4), .i_in_data(in_data), .i_in_parity(in_par),
        .o_out_valid(val4), .i_out_ready(out_ready), .o_out_data(data4), .o_out_parity(par4),
        .o_parity_error(err4), .o_error_count(cnt4), .i_clear_count(clr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic [1:0] t, input logic c, input logic p);
        @(negedge clk);
        check("in_ready_before_send", 32'(rdy8), 1);
        in_data  = d;
        ptype    = t;
        chk      = c;
        in_par   = p;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input logic sel, output int lat);
        lat = 0;
        while (!(sel ? val4 : val8) && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic run(input string tag, input logic [7:0] d, input logic [1:0] t, input logic c,
                       input logic p, input logic exp_par, input logic exp_err);
        int lat;
        send(d, t, c, p);
        wait_out(1'b0, lat);
        check({tag, "_latency"}, 32'(lat), 8);
        check({tag, "_data"}, 32'(data8), 32'(d));
        check({tag, "_parity"}, 32'(par8), 32'(exp_par));
        check({tag, "_error"}, 32'(err8), 32'(exp_err));
        drain();
    endtask

    initial begin
        int lat;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", 32'(rdy8), 1);
        check("rst_out_valid", 32'(val8), 0);
        check("rst_out_data", 32'(data8), 0);
        check("rst_out_parity", 32'(par8), 0);
        check("rst_error", 32'(err8), 0);
        check("rst_count", 32'(cnt8), 0);

        run("gen_even_17", 8'h17, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
        run("gen_odd_17",  8'h17, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
        run("gen_odd_af",  8'hAF, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
        run("gen_even_a9", 8'hA9, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
        run("gen_t11_0f",  8'h0F, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
        run("gen_t00_0f",  8'h0F, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        run("chk_none_0f", 8'h0F, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        check("count_after_gen", 32'(cnt8), 0);

        run("chk_bd_p1", 8'hBD, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1);
        check("count_after_err", 32'(cnt8), 1);
        run("chk_bd_p0", 8'hBD, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
        check("count_after_ok", 32'(cnt8), 1);
        run("chk_odd_ae_p0", 8'hAE, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
        check("count_after_odd_ok", 32'(cnt8), 1);

        send(8'h17, 2'b01, 1'b0, 1'b0);
        wait_out(1'b0, lat);
        check("bp_latency", 32'(lat), 8);
        for (int i = 0; i < 5; i++) begin
            in_data = 8'hFF ^ 8'(i);
            ptype   = 2'(i);
            @(negedge clk);
            check("bp_valid", 32'(val8), 1);
            check("bp_in_ready", 32'(rdy8), 0);
            check("bp_data", 32'(data8), 32'h17);
            check("bp_parity", 32'(par8), 1);
        end
        drain();
        check("bp_valid_after_drain", 32'(val8), 0);
        check("bp_ready_after_drain", 32'(rdy8), 1);

        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clear_alone", 32'(cnt8), 0);
        for (int i = 0; i < 17; i++)
            run("sat_word", 8'hBD, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1);
        check("saturate_15", 32'(cnt8), 15);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        run("pre_clash", 8'hBD, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1);
        check("pre_clash_count", 32'(cnt8), 1);
        send(8'hBD, 2'b10, 1'b1, 1'b1);
        wait_out(1'b0, lat);
        check("clash_error", 32'(err8), 1);
        out_ready = 1'b1;
        clr       = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        clr       = 1'b0;
        check("clash_clear_wins", 32'(cnt8), 0);

        run("pre_rst_err", 8'hBD, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1);
        send(8'h17, 2'b10, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check("mid_shift_busy", 32'(rdy8), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_in_ready", 32'(rdy8), 1);
        check("midrst_out_valid", 32'(val8), 0);
        check("midrst_count", 32'(cnt8), 0);

        send(8'h17, 2'b10, 1'b0, 1'b0);
        wait_out(1'b1, lat);
        check("bpc4_even_latency", 32'(lat), 2);
        check("bpc4_even_parity", 32'(par4), 0);
        check("bpc4_even_data", 32'(data4), 32'h17);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        send(8'h17, 2'b01, 1'b0, 1'b0);
        wait_out(1'b1, lat);
        check("bpc4_odd_latency", 32'(lat), 2);
        check("bpc4_odd_parity", 32'(par4), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
